// File: rtl/fetch_decode_ctrl_if.sv
// Instruction-memory handshake between the fetch/decode controller and its memory.
interface fetch_decode_ctrl_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_valid;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_valid);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_valid);
endinterface

// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode controller for a small RV-subset datapath: fetches words over imem,
// decodes ld/sd/add/sub/addi, pulses register/memory write enables and halts on illegal opcodes.
module fetch_decode_ctrl #(
  parameter int PC_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                run,
  fetch_decode_ctrl_if.master imem,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rd,
  output logic [11:0]         immediate,
  output logic                sub,
  output logic                I_type,
  output logic                R_type,
  output logic                WE_RF,
  output logic                WE_MEM,
  output logic                halted,
  output logic [15:0]         instret
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;

  typedef struct packed {
    logic        legal;
    logic        we_rf;
    logic        we_mem;
    logic        sub;
    logic        i_type;
    logic        r_type;
    logic [4:0]  rd;
    logic [11:0] imm;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t       d;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_ld, is_sd, is_r, is_addi;
    opc     = ir[6:0];
    f3      = ir[14:12];
    f7      = ir[31:25];
    is_ld   = (opc == 7'b0000011) && (f3 == 3'b011);
    is_sd   = (opc == 7'b0100011) && (f3 == 3'b011);
    is_r    = (opc == 7'b0110011) && (f3 == 3'b000) &&
              ((f7 == 7'b0000000) || (f7 == 7'b0100000));
    is_addi = (opc == 7'b0010011) && (f3 == 3'b000);
    d        = '0;
    d.rd     = ir[11:7];
    d.imm    = ir[31:20];
    d.legal  = is_ld | is_sd | is_r | is_addi;
    d.i_type = is_ld | is_sd | is_addi;
    d.r_type = is_r | is_addi;
    d.sub    = is_r & ir[30];
    if (is_sd) begin
      d.rd  = '0;
      d.imm = {ir[31:25], ir[11:7]};
    end
    d.we_mem = is_sd;
    // Writes to x0 are dropped but the instruction still retires.
    d.we_rf  = (is_ld | is_r | is_addi) && (d.rd != 5'd0);
    return d;
  endfunction

  function automatic logic [1:0] enables(input logic [31:0] ir);
    dec_t d;
    d = decode(ir);
    return {d.we_rf, d.we_mem};
  endfunction

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_ir;
  logic [15:0]     r_instret;
  logic            r_halted;
  logic            r_req;
  logic            r_we_rf;
  logic            r_we_mem;

  dec_t            w_dec;
  logic [1:0]      w_in_we;

  assign w_dec   = decode(r_ir);
  assign w_in_we = enables(imem.imem_rdata);

  assign rs1       = r_ir[19:15];
  assign rs2       = r_ir[24:20];
  assign rd        = w_dec.rd;
  assign immediate = w_dec.imm;
  assign sub       = w_dec.sub;
  assign I_type    = w_dec.i_type;
  assign R_type    = w_dec.r_type;

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_pc;
  assign WE_RF          = r_we_rf;
  assign WE_MEM         = r_we_mem;
  assign halted         = r_halted;
  assign instret        = r_instret;

  // Enables are registered from the incoming word so they are high exactly during EXEC.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= 32'h0000_0013;
      r_instret <= '0;
      r_halted  <= 1'b0;
      r_req     <= 1'b0;
      r_we_rf   <= 1'b0;
      r_we_mem  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end
        end
        S_FETCH: begin
          r_state <= S_WAIT;
          r_req   <= 1'b1;
        end
        S_WAIT: begin
          if (imem.imem_valid) begin
            r_ir     <= imem.imem_rdata;
            r_state  <= S_EXEC;
            r_req    <= 1'b0;
            r_we_rf  <= w_in_we[1];
            r_we_mem <= w_in_we[0];
          end
        end
        S_EXEC: begin
          r_we_rf  <= 1'b0;
          r_we_mem <= 1'b0;
          if (w_dec.legal) begin
            r_pc      <= r_pc + 1'b1;
            r_instret <= r_instret + 16'd1;
            r_state   <= S_FETCH;
            r_req     <= 1'b1;
          end else begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
        end
        S_HALT: begin
          r_req    <= 1'b0;
          r_we_rf  <= 1'b0;
          r_we_mem <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Scoreboard bench for fetch_decode_ctrl: a memory driver pushes expected decode
// results as it returns each word; a monitor pops and compares during each EXEC cycle.
module tb_fetch_decode_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        run = 1'b0;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] immediate;
  logic        sub, I_type, R_type, WE_RF, WE_MEM, halted;
  logic [15:0] instret;

  fetch_decode_ctrl_if #(.PC_W(8)) fif ();

  fetch_decode_ctrl #(.PC_W(8)) dut (
    .CLK(CLK), .RST(RST), .run(run), .imem(fif.master),
    .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(immediate),
    .sub(sub), .I_type(I_type), .R_type(R_type),
    .WE_RF(WE_RF), .WE_MEM(WE_MEM), .halted(halted), .instret(instret)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          chk_dec;
    bit          chk_imm;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic        i, r, sub, werf, wemem;
    logic [7:0]  pc;
    logic [15:0] inst;
    logic        hlt;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   acc = 1'b0;
  bit   acc_q = 1'b0;
  int   cyc = 0;
  int   last_exec = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic exp_t mk(input bit cd, input bit ci, input logic [4:0] e_rd,
                              input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                              input logic [11:0] e_imm, input logic e_i, input logic e_r,
                              input logic e_sub, input logic e_werf, input logic e_wemem,
                              input logic [7:0] e_pc, input logic [15:0] e_inst,
                              input logic e_hlt, input int e_gap);
    exp_t e;
    e.chk_dec = cd; e.chk_imm = ci; e.rd = e_rd; e.rs1 = e_rs1; e.rs2 = e_rs2;
    e.imm = e_imm; e.i = e_i; e.r = e_r; e.sub = e_sub; e.werf = e_werf;
    e.wemem = e_wemem; e.pc = e_pc; e.inst = e_inst; e.hlt = e_hlt; e.gap = e_gap;
    return e;
  endfunction

  always @(posedge CLK) begin
    acc_q <= acc;
    cyc   <= cyc + 1;
  end

  // Monitor: the cycle after an accepted word is EXEC; the cycle after that shows PC/instret.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (acc_q) begin
        if (exp_q.size() == 0) begin
          chk("exec_without_expectation", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.gap > 0) chk("exec_spacing", cyc - last_exec, e.gap);
          last_exec = cyc;
          if (e.chk_dec) begin
            chk("rd", rd, e.rd);
            chk("rs1", rs1, e.rs1);
            chk("rs2", rs2, e.rs2);
            chk("I_type", I_type, e.i);
            chk("R_type", R_type, e.r);
            chk("sub", sub, e.sub);
          end
          if (e.chk_imm) chk("immediate", immediate, e.imm);
          chk("WE_RF", WE_RF, e.werf);
          chk("WE_MEM", WE_MEM, e.wemem);
          @(negedge CLK);
          chk("WE_RF_pulse", WE_RF, 1'b0);
          chk("WE_MEM_pulse", WE_MEM, 1'b0);
          chk("pc_after", fif.imem_addr, e.pc);
          chk("instret_after", instret, e.inst);
          chk("halted_after", halted, e.hlt);
        end
      end
    end
  end

  // Memory driver: waits for the FETCH cycle, optionally drives a junk valid there,
  // then returns the word after d WAIT cycles while checking the address is held.
  task automatic fetch(input logic [7:0] a, input logic [31:0] w, input int d,
                       input bit noise, input exp_t e);
    int n = 0;
    while (fif.imem_req !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      chk("imem_req_timeout", 32'd0, 32'd1);
      return;
    end
    chk("fetch_addr", fif.imem_addr, a);
    if (noise) begin
      fif.imem_valid = 1'b1;
      fif.imem_rdata = 32'hFFFF_FFFF;
    end
    @(negedge CLK);
    fif.imem_valid = 1'b0;
    for (int k = 0; k < d; k++) begin
      chk("wait_req", fif.imem_req, 1'b1);
      chk("wait_addr", fif.imem_addr, a);
      @(negedge CLK);
    end
    chk("wait_req", fif.imem_req, 1'b1);
    chk("wait_addr", fif.imem_addr, a);
    fif.imem_valid = 1'b1;
    fif.imem_rdata = w;
    acc = 1'b1;
    exp_q.push_back(e);
    @(negedge CLK);
    fif.imem_valid = 1'b0;
    fif.imem_rdata = '0;
    acc = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    @(negedge CLK);
    run = 1'b0;
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, "_req"}, fif.imem_req, 1'b0);
    chk({tag, "_addr"}, fif.imem_addr, 8'd0);
    chk({tag, "_instret"}, instret, 16'd0);
    chk({tag, "_halted"}, halted, 1'b0);
    chk({tag, "_we"}, {WE_RF, WE_MEM}, 2'b00);
    chk({tag, "_ir_rd"}, rd, 5'd0);
    chk({tag, "_ir_type"}, {I_type, R_type}, 2'b11);
  endtask

  task automatic check_halt(input logic [7:0] a, input logic [15:0] n);
    run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("halt_req", fif.imem_req, 1'b0);
      chk("halt_we", {WE_RF, WE_MEM}, 2'b00);
      chk("halt_flag", halted, 1'b1);
      chk("halt_pc", fif.imem_addr, a);
      chk("halt_instret", instret, n);
    end
    run = 1'b0;
  endtask

  initial begin
    int n;
    fif.imem_valid = 1'b0;
    fif.imem_rdata = '0;
    repeat (3) @(negedge CLK);
    check_idle_reset("reset");
    RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("idle_req", fif.imem_req, 1'b0);
    end

    // Program 1: all legal forms, then an illegal funct3 at address 6.
    pulse_run();
    fetch(8'd0, 32'h0100_3083, 2, 1'b0,
          mk(1, 1, 5'd1, 5'd0, 5'd16, 12'd16, 1, 0, 0, 1, 0, 8'd1, 16'd1, 0, 0));
    fetch(8'd1, 32'h0050_8533, 0, 1'b1,
          mk(1, 0, 5'd10, 5'd1, 5'd5, 12'd0, 0, 1, 0, 1, 0, 8'd2, 16'd2, 0, 0));
    fetch(8'd2, 32'h4012_8A33, 0, 1'b0,
          mk(1, 0, 5'd20, 5'd5, 5'd1, 12'd0, 0, 1, 1, 1, 0, 8'd3, 16'd3, 0, 3));
    fetch(8'd3, 32'h00A0_3523, 0, 1'b0,
          mk(1, 1, 5'd0, 5'd0, 5'd10, 12'd10, 1, 0, 0, 0, 1, 8'd4, 16'd4, 0, 3));
    fetch(8'd4, 32'hE6FA_8F13, 0, 1'b0,
          mk(1, 1, 5'd30, 5'd21, 5'd15, 12'hE6F, 1, 1, 0, 1, 0, 8'd5, 16'd5, 0, 3));
    fetch(8'd5, 32'h0000_0013, 1, 1'b0,
          mk(1, 1, 5'd0, 5'd0, 5'd0, 12'd0, 1, 1, 0, 0, 0, 8'd6, 16'd6, 0, 0));
    fetch(8'd6, 32'h0000_1033, 0, 1'b0,
          mk(0, 0, 5'd0, 5'd0, 5'd0, 12'd0, 0, 0, 0, 0, 0, 8'd6, 16'd6, 1, 0));
    check_halt(8'd6, 16'd6);

    // Program 2: all-ones word at PC=3.
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check_idle_reset("reset2");
    RST = 1'b0;
    @(negedge CLK);
    pulse_run();
    for (int k = 0; k < 3; k++)
      fetch(k[7:0], 32'h0000_0013, 0, 1'b0,
            mk(1, 1, 5'd0, 5'd0, 5'd0, 12'd0, 1, 1, 0, 0, 0, 8'(k + 1), 16'(k + 1), 0, 0));
    fetch(8'd3, 32'hFFFF_FFFF, 0, 1'b0,
          mk(0, 0, 5'd0, 5'd0, 5'd0, 12'd0, 0, 0, 0, 0, 0, 8'd3, 16'd3, 1, 0));
    check_halt(8'd3, 16'd3);

    // Reset mid-WAIT with a valid word presented in the same cycle.
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    pulse_run();
    n = 0;
    while (fif.imem_req !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("midwait_fetch_seen", fif.imem_req, 1'b1);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    fif.imem_valid = 1'b1;
    fif.imem_rdata = 32'h0100_3083;
    @(negedge CLK);
    RST = 1'b0;
    fif.imem_valid = 1'b0;
    fif.imem_rdata = '0;
    check_idle_reset("midwait_reset");
    repeat (2) @(negedge CLK);
    chk("midwait_idle_req", fif.imem_req, 1'b0);
    pulse_run();
    fetch(8'd0, 32'h0100_3083, 0, 1'b0,
          mk(1, 1, 5'd1, 5'd0, 5'd16, 12'd16, 1, 0, 0, 1, 0, 8'd1, 16'd1, 0, 0));

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
